// File: rtl/rsa_xfer_seq.sv
// Moves operand words from the input FIFO into a modexp engine, fires it, and
// drains the result words into the output FIFO, with pre-checks, abort and timeout.
module rsa_xfer_seq #(
  parameter int DW       = 32,
  parameter int KEY_BITS = 2048,
  parameter int MAX_OPS  = 3,
  parameter int CNT_W    = 8,
  parameter int TMO_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       ops,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DW-1:0]    in_dat,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_dat,
  input  logic [CNT_W-1:0] out_room,
  output logic             eng_ld_vld,
  input  logic             eng_ld_rdy,
  output logic [DW-1:0]    eng_ld_dat,
  output logic             eng_go,
  output logic             eng_abort,
  input  logic             eng_done,
  input  logic             eng_res_vld,
  output logic             eng_res_rdy,
  input  logic [DW-1:0]    eng_res_dat,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  // state | meaning
  // IDLE  | waiting for start; pre-checks run here
  // LOAD  | streaming operand words FIFO -> engine
  // GO    | eng_go high for this single cycle
  // RUN   | waiting for eng_done, timeout counter running
  // DRAIN | streaming result words engine -> FIFO
  // FIN   | set done, return to IDLE

  localparam int NW = KEY_BITS / DW;
  localparam int CW = $clog2(MAX_OPS * NW + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t            state;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [CW-1:0]     total;
  logic [TMO_W-1:0]  tmo;
  logic [31:0]       need;
  logic              ld_x;
  logic              res_x;
  logic              ops_bad;
  logic              space_bad;

  assign need      = 32'(ops) * 32'(NW);
  assign ops_bad   = (ops == 2'd0) || (32'(ops) > 32'(MAX_OPS));
  assign space_bad = (32'(in_cnt) < need) || (32'(out_room) < 32'(NW));

  // Handshakes are pure pass-through while their state is active, 0 otherwise.
  assign busy        = (state != S_IDLE);
  assign eng_ld_vld  = (state == S_LOAD) & in_vld;
  assign eng_ld_dat  = (state == S_LOAD) ? in_dat : '0;
  assign in_rdy      = (state == S_LOAD) & in_vld & eng_ld_rdy;
  assign out_vld     = (state == S_DRAIN) & eng_res_vld;
  assign out_dat     = (state == S_DRAIN) ? eng_res_dat : '0;
  assign eng_res_rdy = (state == S_DRAIN) & out_rdy;
  assign ld_x        = in_rdy;
  assign res_x       = out_vld & out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      total     <= '0;
      tmo       <= '0;
      eng_go    <= 1'b0;
      eng_abort <= 1'b0;
      done      <= 1'b0;
      err       <= 2'd0;
    end else if (clr) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      total     <= '0;
      tmo       <= '0;
      eng_go    <= 1'b0;
      eng_abort <= 1'b0;
      done      <= 1'b0;
      err       <= 2'd0;
    end else begin
      eng_go    <= 1'b0;
      eng_abort <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        eng_abort <= 1'b1;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (ops_bad) begin
                err <= 2'd2;
              end else if (space_bad) begin
                err <= 2'd1;
              end else begin
                total <= CW'(need);
                wcnt  <= '0;
                done  <= 1'b0;
                err   <= 2'd0;
                state <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (ld_x) begin
              wcnt <= wcnt + CW'(1);
              if (wcnt == total - CW'(1)) begin
                eng_go <= 1'b1;
                state  <= S_GO;
              end
            end
          end
          S_GO: begin
            tmo   <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            if (eng_done) begin
              rcnt  <= '0;
              state <= S_DRAIN;
            end else if (&tmo) begin
              err       <= 2'd3;
              eng_abort <= 1'b1;
              state     <= S_IDLE;
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end
          S_DRAIN: begin
            if (res_x) begin
              rcnt <= rcnt + CW'(1);
              if (rcnt == CW'(NW - 1)) state <= S_FIN;
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
